// File: rtl/mul_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// rv32i_types: shared RV32 M-extension types for the multiply sequencer.
//   mul_ops        - operation select driven to the multiplier
//   F3_*           - funct3 encodings of the multiply instructions
//   funct3_to_op   - decode of funct3 into mul_ops
//   select_result  - picks the rd value out of a 64-bit product
// -----------------------------------------------------------------------------
package rv32i_types;

    typedef enum logic [1:0] {
        mul_lo = 2'b00,   // MUL    : low word, signedness irrelevant
        mul_ss = 2'b01,   // MULH   : signed x signed
        mul_su = 2'b10,   // MULHSU : signed x unsigned
        mul_uu = 2'b11    // MULHU  : unsigned x unsigned
    } mul_ops;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;

    function automatic mul_ops funct3_to_op(input logic [2:0] funct3);
        mul_ops op;
        case (funct3)
            F3_MUL:    op = mul_lo;
            F3_MULH:   op = mul_ss;
            F3_MULHSU: op = mul_su;
            F3_MULHU:  op = mul_uu;
            default:   op = mul_lo;
        endcase
        return op;
    endfunction

    // MUL takes the low word; every high-word variant takes bits 63:32.
    function automatic logic [31:0] select_result(input mul_ops op, input logic [63:0] product);
        logic [31:0] rd;
        if (op == mul_lo) begin
            rd = product[31:0];
        end else begin
            rd = product[63:32];
        end
        return rd;
    endfunction

endpackage

// File: rtl/mul_sequencer_if.sv
// -----------------------------------------------------------------------------
// mul_sequencer_if: EX-stage request/response and multiplier handshake.
//   master - environment side: issues requests, flush, returns products
//   slave  - sequencer side: stall/response and multiplier command
// -----------------------------------------------------------------------------
interface mul_sequencer_if;
    import rv32i_types::*;

    logic        req_valid;
    logic [2:0]  req_funct3;
    logic [31:0] req_rs1;
    logic [31:0] req_rs2;
    logic        flush;
    logic        stall;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        mul_start;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    mul_ops      mul_op;
    logic [63:0] mul_result;
    logic        mul_done;

    modport master (
        output req_valid, req_funct3, req_rs1, req_rs2, flush, mul_result, mul_done,
        input  stall, resp_valid, resp_data, mul_start, mul_a, mul_b, mul_op
    );

    modport slave (
        input  req_valid, req_funct3, req_rs1, req_rs2, flush, mul_result, mul_done,
        output stall, resp_valid, resp_data, mul_start, mul_a, mul_b, mul_op
    );

endinterface

// File: rtl/mul_sequencer_cache.sv
// -----------------------------------------------------------------------------
// mul_result_cache: single-entry last-result cache for the multiply sequencer.
//   clk, rst                       - clock, synchronous active-high reset
//   lookup_rs1/rs2/op -> hit       - combinational compare against the entry
//   hit_product                    - stored 64-bit product
//   wr_en, wr_rs1/rs2/op/product   - overwrite the entry and mark it valid
// A MUL request hits on any stored op: the low product word does not depend
// on operand signedness.
// -----------------------------------------------------------------------------
module mul_result_cache
    import rv32i_types::*;
#(
    parameter int CACHE_EN = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] lookup_rs1,
    input  logic [31:0] lookup_rs2,
    input  mul_ops      lookup_op,
    output logic        hit,
    output logic [63:0] hit_product,
    input  logic        wr_en,
    input  logic [31:0] wr_rs1,
    input  logic [31:0] wr_rs2,
    input  mul_ops      wr_op,
    input  logic [63:0] wr_product
);

    logic        valid_r;
    logic [31:0] rs1_r;
    logic [31:0] rs2_r;
    mul_ops      op_r;
    logic [63:0] product_r;

    // Entry storage: cleared on reset, replaced on every write.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r   <= 1'b0;
            rs1_r     <= 32'd0;
            rs2_r     <= 32'd0;
            op_r      <= mul_lo;
            product_r <= 64'd0;
        end else if (wr_en) begin
            valid_r   <= 1'b1;
            rs1_r     <= wr_rs1;
            rs2_r     <= wr_rs2;
            op_r      <= wr_op;
            product_r <= wr_product;
        end
    end

    // Hit compare against the single stored entry.
    always_comb begin
        hit = 1'b0;
        if ((CACHE_EN != 0) && valid_r && (lookup_rs1 == rs1_r) && (lookup_rs2 == rs2_r)
            && ((lookup_op == op_r) || (lookup_op == mul_lo))) begin
            hit = 1'b1;
        end else begin
            hit = 1'b0;
        end
    end

    assign hit_product = product_r;

endmodule

// File: rtl/mul_sequencer.sv
// -----------------------------------------------------------------------------
// mul_sequencer: sequences RV32 M-extension multiplies from EX onto a
// multi-cycle multiplier, short-circuiting repeats through a result cache.
//   clk, rst         - clock, synchronous active-high reset (shared with the
//                      multiplier, so no stale mul_done follows a reset)
//   bus (slave)      - request/flush/stall/response and multiplier handshake
//   perf_issue_cnt   - multiplier issues (wraps)
//   perf_hit_cnt     - cache hits (wraps)
// A flush after mul_start has gone out parks the FSM in DRAIN until the
// multiplier's mul_done, whose result is thrown away.
// -----------------------------------------------------------------------------
module mul_sequencer
    import rv32i_types::*;
#(
    parameter int CACHE_EN = 1
) (
    input  logic         clk,
    input  logic         rst,
    mul_sequencer_if.slave bus,
    output logic [31:0]  perf_issue_cnt,
    output logic [31:0]  perf_hit_cnt
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        DRAIN = 3'd3,
        RESP  = 3'd4
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic        cache_wr_s;
    logic        accept_s;
    logic        hit_s;
    logic [63:0] hit_product_s;
    mul_ops      req_op_s;
    logic [31:0] mul_a_r;
    logic [31:0] mul_b_r;
    mul_ops      mul_op_r;
    logic [31:0] resp_data_r;
    logic [31:0] issue_cnt_r;
    logic [31:0] hit_cnt_r;

    assign req_op_s = funct3_to_op(bus.req_funct3);
    assign accept_s = (state_r == IDLE) && bus.req_valid && !bus.flush;

    mul_result_cache #(.CACHE_EN(CACHE_EN)) u_cache (
        .clk         (clk),
        .rst         (rst),
        .lookup_rs1  (bus.req_rs1),
        .lookup_rs2  (bus.req_rs2),
        .lookup_op   (req_op_s),
        .hit         (hit_s),
        .hit_product (hit_product_s),
        .wr_en       (cache_wr_s),
        .wr_rs1      (mul_a_r),
        .wr_rs2      (mul_b_r),
        .wr_op       (mul_op_r),
        .wr_product  (bus.mul_result)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode and cache write strobe.
    always_comb begin
        state_s    = state_r;
        cache_wr_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_s = hit_s ? RESP : ISSUE;
                end else begin
                    state_s = IDLE;
                end
            end
            // mul_start goes out regardless of flush, so a flush must drain.
            ISSUE: state_s = bus.flush ? DRAIN : WAIT;
            WAIT: begin
                if (bus.flush) begin
                    state_s = bus.mul_done ? IDLE : DRAIN;
                end else if (bus.mul_done) begin
                    state_s    = RESP;
                    cache_wr_s = 1'b1;
                end else begin
                    state_s = WAIT;
                end
            end
            DRAIN: state_s = bus.mul_done ? IDLE : DRAIN;
            RESP:  state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Handshake outputs decoded from the registered state.
    always_comb begin
        bus.mul_start  = (state_r == ISSUE);
        bus.resp_valid = (state_r == RESP) && !bus.flush;
        if (state_r == IDLE) begin
            bus.stall = bus.req_valid;
        end else begin
            bus.stall = !((state_r == RESP) && !bus.flush);
        end
    end

    // Operand/op capture, response latch and performance counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            mul_a_r     <= 32'd0;
            mul_b_r     <= 32'd0;
            mul_op_r    <= mul_lo;
            resp_data_r <= 32'd0;
            issue_cnt_r <= 32'd0;
            hit_cnt_r   <= 32'd0;
        end else begin
            if (accept_s && hit_s) begin
                resp_data_r <= select_result(req_op_s, hit_product_s);
                hit_cnt_r   <= hit_cnt_r + 32'd1;
            end else if (accept_s) begin
                mul_a_r  <= bus.req_rs1;
                mul_b_r  <= bus.req_rs2;
                mul_op_r <= req_op_s;
            end
            if (state_r == ISSUE) begin
                issue_cnt_r <= issue_cnt_r + 32'd1;
            end
            if (cache_wr_s) begin
                resp_data_r <= select_result(mul_op_r, bus.mul_result);
            end
        end
    end

    assign bus.mul_a       = mul_a_r;
    assign bus.mul_b       = mul_b_r;
    assign bus.mul_op      = mul_op_r;
    assign bus.resp_data   = resp_data_r;
    assign perf_issue_cnt  = issue_cnt_r;
    assign perf_hit_cnt    = hit_cnt_r;

endmodule

// File: tb/tb_mul_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mul_sequencer: directed bench for mul_sequencer with a fixed-latency
// behavioural multiplier (mul_done arrives LAT cycles after mul_start).
// -----------------------------------------------------------------------------
module tb_mul_sequencer;
    import rv32i_types::*;

    localparam int LAT = 4;

    logic        clk;
    logic        rst;
    logic [31:0] perf_issue_cnt;
    logic [31:0] perf_hit_cnt;

    int vectors     = 0;
    int miscompares = 0;
    int start_seen  = 0;
    int done_seen   = 0;

    mul_sequencer_if bus_if ();

    mul_sequencer #(.CACHE_EN(1)) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus_if),
        .perf_issue_cnt (perf_issue_cnt),
        .perf_hit_cnt   (perf_hit_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural multiplier, evaluated mid-cycle.
    initial begin
        int busy;
        int cnt;
        logic [63:0] ea, eb, prod;
        busy = 0;
        cnt  = 0;
        prod = 64'd0;
        bus_if.mul_done   = 1'b0;
        bus_if.mul_result = 64'd0;
        forever begin
            @(negedge clk);
            bus_if.mul_done = 1'b0;
            if (rst) begin
                busy = 0;
                cnt  = 0;
            end else begin
                if (bus_if.mul_start) start_seen++;
                if (busy != 0) begin
                    cnt--;
                    if (cnt == 0) begin
                        busy = 0;
                        bus_if.mul_done   = 1'b1;
                        bus_if.mul_result = prod;
                        done_seen++;
                    end
                end else if (bus_if.mul_start) begin
                    busy = 1;
                    cnt  = LAT;
                    ea = (bus_if.mul_op == mul_ss || bus_if.mul_op == mul_su) ?
                         {{32{bus_if.mul_a[31]}}, bus_if.mul_a} : {32'd0, bus_if.mul_a};
                    eb = (bus_if.mul_op == mul_ss) ?
                         {{32{bus_if.mul_b[31]}}, bus_if.mul_b} : {32'd0, bus_if.mul_b};
                    prod = ea * eb;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Presents one request (entered at posedge+1), returns data and latency in cycles.
    task automatic do_req(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] data, output int lat);
        bus_if.req_valid  = 1'b1;
        bus_if.req_funct3 = f3;
        bus_if.req_rs1    = a;
        bus_if.req_rs2    = b;
        lat  = -1;
        data = 32'd0;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if (bus_if.resp_valid) begin
                lat  = n;
                data = bus_if.resp_data;
                break;
            end
            tick();
        end
        tick();
        bus_if.req_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] data;
        int lat;
        int s0;
        int d0;
        int n;
        logic rv_seen;

        rst = 1'b1;
        bus_if.req_valid  = 1'b0;
        bus_if.req_funct3 = 3'b000;
        bus_if.req_rs1    = 32'd0;
        bus_if.req_rs2    = 32'd0;
        bus_if.flush      = 1'b0;

        // Reset state
        tick();
        @(negedge clk);
        check("rst_stall", bus_if.stall, 1'b0);
        check("rst_resp_valid", bus_if.resp_valid, 1'b0);
        check("rst_mul_start", bus_if.mul_start, 1'b0);
        check("rst_mul_a", bus_if.mul_a, 32'd0);
        check("rst_mul_b", bus_if.mul_b, 32'd0);
        check("rst_resp_data", bus_if.resp_data, 32'd0);
        check("rst_mul_op", bus_if.mul_op, mul_lo);
        check("rst_perf_issue", perf_issue_cnt, 32'd0);
        check("rst_perf_hit", perf_hit_cnt, 32'd0);
        bus_if.req_valid = 1'b1;
        #1;
        check("rst_stall_follows_req", bus_if.stall, 1'b1);
        tick();
        bus_if.req_valid = 1'b0;
        rst = 1'b0;

        // MUL 7 x 6
        s0 = start_seen;
        do_req(3'b000, 32'd7, 32'd6, data, lat);
        check("mul_7x6_data", data, 32'h0000002A);
        check("mul_7x6_lat", lat, 2 + LAT);
        check("mul_7x6_starts", start_seen - s0, 1);
        check("mul_7x6_perf_issue", perf_issue_cnt, 32'd1);

        // MULHU / MULH on all-ones: different op must re-issue
        do_req(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, data, lat);
        check("mulhu_ones_data", data, 32'hFFFFFFFE);
        s0 = start_seen;
        do_req(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, data, lat);
        check("mulh_ones_data", data, 32'h00000000);
        check("mulh_ones_starts", start_seen - s0, 1);
        check("mulh_ones_perf_issue", perf_issue_cnt, 32'd3);

        // MULHSU -1 x 2
        do_req(3'b010, 32'hFFFFFFFF, 32'd2, data, lat);
        check("mulhsu_data", data, 32'hFFFFFFFF);

        // MULH 0x80000000 x 3, then MUL hits the cache
        do_req(3'b001, 32'h80000000, 32'd3, data, lat);
        check("mulh_8x3_data", data, 32'hFFFFFFFE);
        s0 = start_seen;
        do_req(3'b000, 32'h80000000, 32'd3, data, lat);
        check("hit_mul_data", data, 32'h80000000);
        check("hit_mul_lat", lat, 1);
        check("hit_mul_starts", start_seen - s0, 0);
        check("hit_perf_hit", perf_hit_cnt, 32'd1);
        check("hit_perf_issue", perf_issue_cnt, 32'd5);

        // Flush two cycles after mul_start: drain, no response
        s0 = start_seen;
        d0 = done_seen;
        bus_if.req_valid  = 1'b1;
        bus_if.req_funct3 = 3'b000;
        bus_if.req_rs1    = 32'd9;
        bus_if.req_rs2    = 32'd9;
        @(negedge clk);
        check("flush_stall_req", bus_if.stall, 1'b1);
        tick();
        @(negedge clk);
        check("flush_mul_start", bus_if.mul_start, 1'b1);
        tick();
        tick();
        bus_if.flush = 1'b1;
        @(negedge clk);
        check("flush_resp_valid", bus_if.resp_valid, 1'b0);
        check("flush_stall_wait", bus_if.stall, 1'b1);
        tick();
        bus_if.flush     = 1'b0;
        bus_if.req_valid = 1'b0;
        n = -1;
        rv_seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus_if.resp_valid) rv_seen = 1'b1;
            if (!bus_if.stall) begin
                n = i;
                break;
            end
            tick();
        end
        check("flush_stall_release", n, 2);
        check("flush_no_resp", rv_seen, 1'b0);
        check("flush_done_seen", done_seen - d0, 1);
        check("flush_starts", start_seen - s0, 1);
        tick();

        // Cache untouched by the drained product
        do_req(3'b000, 32'h80000000, 32'd3, data, lat);
        check("post_flush_hit_lat", lat, 1);
        check("post_flush_hit_data", data, 32'h80000000);
        check("post_flush_perf_hit", perf_hit_cnt, 32'd2);
        s0 = start_seen;
        do_req(3'b000, 32'd9, 32'd9, data, lat);
        check("mul_9x9_data", data, 32'h00000051);
        check("mul_9x9_starts", start_seen - s0, 1);
        check("mul_9x9_perf_issue", perf_issue_cnt, 32'd7);

        // Flush in RESP on a hit: response suppressed, cache stands
        bus_if.req_valid  = 1'b1;
        bus_if.req_funct3 = 3'b000;
        bus_if.req_rs1    = 32'd9;
        bus_if.req_rs2    = 32'd9;
        tick();
        bus_if.flush = 1'b1;
        @(negedge clk);
        check("resp_flush_valid", bus_if.resp_valid, 1'b0);
        check("resp_flush_perf_hit", perf_hit_cnt, 32'd3);
        tick();
        bus_if.flush     = 1'b0;
        bus_if.req_valid = 1'b0;
        @(negedge clk);
        check("resp_flush_idle_stall", bus_if.stall, 1'b0);
        tick();
        do_req(3'b000, 32'd9, 32'd9, data, lat);
        check("rehit_9x9_lat", lat, 1);
        check("rehit_9x9_data", data, 32'h00000051);

        // Reset while in WAIT
        bus_if.req_valid  = 1'b1;
        bus_if.req_funct3 = 3'b000;
        bus_if.req_rs1    = 32'd2;
        bus_if.req_rs2    = 32'd2;
        tick();
        tick();
        rst = 1'b1;
        bus_if.req_valid = 1'b0;
        tick();
        @(negedge clk);
        check("wait_rst_mul_start", bus_if.mul_start, 1'b0);
        check("wait_rst_stall", bus_if.stall, 1'b0);
        check("wait_rst_resp_valid", bus_if.resp_valid, 1'b0);
        check("wait_rst_perf_issue", perf_issue_cnt, 32'd0);
        check("wait_rst_mul_a", bus_if.mul_a, 32'd0);
        tick();
        rst = 1'b0;
        d0 = done_seen;
        do_req(3'b000, 32'd3, 32'd5, data, lat);
        check("mul_3x5_data", data, 32'h0000000F);
        check("mul_3x5_lat", lat, 2 + LAT);
        check("mul_3x5_perf_issue", perf_issue_cnt, 32'd1);
        check("mul_3x5_done_seen", done_seen - d0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
